// File: rtl/fpu_ss_offload_buffer.sv
// Commit-aware FIFO of offloaded FPU instructions; head released 1 cycle after push+commit, in_ready_o low when full.
// FPU_SS_SPEC_COMMIT_EN enables commit/kill tracking; otherwise entries are committed on push (plain FIFO).
module fpu_ss_offload_buffer #(
    parameter int unsigned NUM_RS    = 3,
    parameter int unsigned RFR_WIDTH = 32,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [31:0]                   in_instr_i,
    input  logic [1:0]                    in_mode_i,
    input  logic [ID_WIDTH-1:0]           in_id_i,
    input  logic [NUM_RS*RFR_WIDTH-1:0]   in_rs_i,
    input  logic                          commit_valid_i,
    input  logic [ID_WIDTH-1:0]           commit_id_i,
    input  logic                          commit_kill_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   out_instr_o,
    output logic [1:0]                    out_mode_o,
    output logic [ID_WIDTH-1:0]           out_id_o,
    output logic [NUM_RS*RFR_WIDTH-1:0]   out_rs_o,
    output logic [$clog2(DEPTH):0]        usage_o
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned UW  = PW + 1;
    localparam int unsigned RSW = NUM_RS * RFR_WIDTH;

    logic [31:0]          instr_q [DEPTH];
    logic [1:0]           mode_q  [DEPTH];
    logic [ID_WIDTH-1:0]  id_q    [DEPTH];
    logic [RSW-1:0]       rs_q    [DEPTH];
    logic [DEPTH-1:0]     vld_q, cmt_q, kil_q;
    logic [DEPTH-1:0]     vld_d, cmt_d, kil_d;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [UW-1:0]        usage;

    logic push, pop, head_kill, advance;

    assign in_ready_o  = rst_ni && (usage < UW'(DEPTH));
    assign push        = in_valid_i && in_ready_o;
    assign head_kill   = vld_q[rd_ptr] && kil_q[rd_ptr];
    assign out_valid_o = vld_q[rd_ptr] && cmt_q[rd_ptr] && !kil_q[rd_ptr];
    assign pop         = out_valid_o && out_ready_i;
    // A killed head is dropped without being presented: one bubble cycle.
    assign advance     = pop || head_kill;

    assign out_instr_o = instr_q[rd_ptr];
    assign out_mode_o  = mode_q[rd_ptr];
    assign out_id_o    = id_q[rd_ptr];
    assign out_rs_o    = rs_q[rd_ptr];
    assign usage_o     = usage;

`ifndef FPU_SS_SPEC_COMMIT_EN
    logic unused_commit;
    assign unused_commit = ^{commit_valid_i, commit_id_i, commit_kill_i};
`endif

    always_comb begin
        vld_d = vld_q;
        cmt_d = cmt_q;
        kil_d = kil_q;
`ifdef FPU_SS_SPEC_COMMIT_EN
        // Only still-speculative entries react; resolved ones are final.
        if (commit_valid_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (vld_q[i] && !cmt_q[i] && !kil_q[i] && (id_q[i] == commit_id_i)) begin
                    if (commit_kill_i) kil_d[i] = 1'b1;
                    else               cmt_d[i] = 1'b1;
                end
            end
        end
`endif
        if (advance) begin
            vld_d[rd_ptr] = 1'b0;
            cmt_d[rd_ptr] = 1'b0;
            kil_d[rd_ptr] = 1'b0;
        end
        if (push) begin
            vld_d[wr_ptr] = 1'b1;
`ifdef FPU_SS_SPEC_COMMIT_EN
            cmt_d[wr_ptr] = commit_valid_i && !commit_kill_i && (in_id_i == commit_id_i);
            kil_d[wr_ptr] = commit_valid_i &&  commit_kill_i && (in_id_i == commit_id_i);
`else
            cmt_d[wr_ptr] = 1'b1;
            kil_d[wr_ptr] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            cmt_q  <= '0;
            kil_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else begin
            vld_q <= vld_d;
            cmt_q <= cmt_d;
            kil_q <= kil_d;
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (advance) rd_ptr <= rd_ptr + 1'b1;
            if (push && !advance)      usage <= usage + 1'b1;
            else if (!push && advance) usage <= usage - 1'b1;
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr] <= in_instr_i;
            mode_q[wr_ptr]  <= in_mode_i;
            id_q[wr_ptr]    <= in_id_i;
            rs_q[wr_ptr]    <= in_rs_i;
        end
    end
endmodule

// File: doc/fpu_ss_offload_buffer.md
# fpu_ss_offload_buffer

Parametrised, commit-aware buffer between the cv-x-if issue interface and the FPU subsystem decoder/FPnew front-end. It holds accepted offloaded instructions with their source operands, and releases an instruction only once the core has committed it. Instructions killed by the core are discarded. It generalises the fixed three-operand, 4-bit-ID offloaded record to configurable operand count, operand width, ID width and depth.

## Interface
Parameters:
- `NUM_RS`, 3: number of source operands per entry.
- `RFR_WIDTH`, 32: width of each source operand.
- `ID_WIDTH`, 4: width of the instruction ID.
- `DEPTH`, 4: number of entries. Must be a power of two, ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Synchronous, active-low.
- `in_valid_i`  in  1  offloaded instruction valid.
- `in_ready_o`  out  1  buffer can accept an instruction.
- `in_instr_i`  in  32  instruction word.
- `in_mode_i`  in  2  privilege mode.
- `in_id_i`  in  ID_WIDTH  instruction ID.
- `in_rs_i`  in  NUM_RS*RFR_WIDTH  operands; rs[k] is at bits [k*RFR_WIDTH +: RFR_WIDTH].
- `commit_valid_i`  in  1  commit event.
- `commit_id_i`  in  ID_WIDTH  ID being committed or killed.
- `commit_kill_i`  in  1  1 = kill, 0 = commit.
- `out_valid_o`  out  1  head entry is committed and available.
- `out_ready_i`  in  1  consumer takes the head.
- `out_instr_o`  out  32  head instruction.
- `out_mode_o`  out  2  head mode.
- `out_id_o`  out  ID_WIDTH  head ID.
- `out_rs_o`  out  NUM_RS*RFR_WIDTH  head operands.
- `usage_o`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {instr, mode, id, rs, valid, committed, killed}. Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Push: fires when `in_valid_i && in_ready_o`. The entry is written at the write pointer with committed=0 and killed=0.
- Commit event: every valid entry whose id equals `commit_id_i` sets killed if `commit_kill_i`=1, otherwise committed.
  - A commit in the same cycle as a push with an equal ID applies to the pushed entry as well.
  - A commit matching no entry is ignored.
  - An entry that is already committed or killed is not changed by further commits.
- Head handling, evaluated once per cycle:
  - head valid and killed: the entry is dropped. The read pointer advances and `out_valid_o` stays 0 that cycle.
  - head valid and committed: `out_valid_o`=1. The pop fires when `out_ready_i`=1.
  - head valid but uncommitted, or buffer empty: `out_valid_o`=0.
- `out_*` data is driven from the head register with no combinational path from `in_*`.
- `in_ready_o` = (usage < DEPTH). It does not depend on `out_ready_i`, so when full a push cannot be combined with a same-cycle pop.
- Push and pop (or drop) in the same cycle leave `usage_o` unchanged.
- `out_*` data is don't-care when `out_valid_o`=0.

## Timing
- Reset (rst_ni=0 sampled on a clock edge) clears all entry valid/committed/killed bits, both pointers and usage.
- Outputs after reset: `in_ready_o`=1, `out_valid_o`=0, `usage_o`=0. While `rst_ni` is held low, `in_ready_o` is forced to 0.
- A reset during operation discards all entries, including committed entries not yet popped.
- Minimum latency is 1 cycle: push and commit in cycle N give `out_valid_o`=1 in cycle N+1.
- A commit in a later cycle M gives `out_valid_o` in M+1.
- Sustained throughput is one pop per cycle when entries are committed ahead of the head.
- Each killed head costs one bubble cycle.

## Configuration
- `FPU_SS_SPEC_COMMIT_EN` defined: commit and kill tracking operates as described above.
- Not defined: entries are marked committed on push and the `commit_*` inputs are ignored. The block then behaves as a plain FIFO with `out_valid_o` = (usage≠0) and a 1-cycle latency.

## Test plan
- Fill and drain, DEPTH=4: push IDs 0–3 with no commit → `in_ready_o`=0 and `usage_o`=4, `out_valid_o`=0. Commit IDs 0–3 → pops in order 0,1,2,3, then `usage_o`=0.
- Same-cycle push and commit of ID 5 into an empty buffer → `out_valid_o`=1 on the next cycle with `out_id_o`=5 and operands matching the input.
- Push IDs 1,2,3, kill 1, commit 2 → one bubble cycle, then ID 2 presented; ID 3 is held until it is committed.
- Out-of-order commits: commit ID 3 before ID 2 → ID 3 is not presented until ID 2 is committed and popped (order preserved).
- Pointer wrap: 10 push/commit/pop rounds with `out_ready_i` toggling → data matches the scoreboard and `usage_o` never exceeds 4.
- Reset asserted with 3 entries held → next cycle `usage_o`=0, `out_valid_o`=0, `in_ready_o`=1. With the macro undefined, a push gives `out_valid_o`=1 after 1 cycle without any commit.
